// File: rtl/deser_fifo.sv
`default_nettype none
// deser_fifo: serial-to-parallel receiver feeding a DEPTH-entry word FIFO.
// Single clock, asynchronous active-low reset; bit order and full policy are parameters.
module deser_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                       clock1M,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  input  logic                       ovf_clr_in,
  output logic                       status_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {RECV = 1'b0, PUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    len_q;
  logic             dv_q;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full, empty, pop, push, drop;
  logic [WIDTH-1:0] shifted;

  assign full  = (len_q == LW'(DEPTH));
  assign empty = (len_q == '0);
  assign pop   = dequeue_in & ~empty;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_q[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign shifted = {data_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    push       = 1'b0;
    drop       = 1'b0;
    status_out = 1'b0;
    case (state_q)
      RECV: begin
        status_out = 1'b1;
        if (write_in) begin
          shift_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            hold_d  = shifted;
            state_d = PUSH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PUSH: begin
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        if (!full || pop) begin
          push    = 1'b1;
          state_d = RECV;
        end else if (DROP_ON_FULL) begin
          drop    = 1'b1;
          state_d = RECV;
        end
      end
      default: state_d = RECV;
    endcase
    ovf_d = drop ? 1'b1 : (ovf_clr_in ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state_q <= RECV;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      dv_q    <= pop;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        data_q <= mem[rptr_q];
      end
      case ({push, pop})
        2'b10:   len_q <= len_q + LW'(1);
        2'b01:   len_q <= len_q - LW'(1);
        default: len_q <= len_q;
      endcase
    end
  end

  // Storage needs no reset; contents are unreachable until rewritten.
  always_ff @(posedge clock1M) begin
    if (push) mem[wptr_q] <= hold_q;
  end

  assign data_out     = data_q;
  assign data_valid   = dv_q;
  assign len_out      = len_q;
  assign full_out     = full;
  assign empty_out    = empty;
  assign overflow_out = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_deser_fifo.sv
`default_nettype none
// tb_deser_fifo: two configurations (MSB-first/stall and LSB-first/drop) checked
// cycle by cycle against a queue-based model of the receiver and FIFO.
module tb_deser_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic a_d = 0, a_w = 0, a_deq = 0, a_clr = 0;
  logic b_d = 0, b_w = 0, b_deq = 0, b_clr = 0;
  logic a_status, a_dv, a_full, a_empty, a_ovf;
  logic b_status, b_dv, b_full, b_empty, b_ovf;
  logic [7:0] a_dout, b_dout;
  logic [3:0] a_len, b_len;

  deser_fifo #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b1), .DROP_ON_FULL(1'b0)) u_a (
    .clock1M(clk), .reset(rst_n), .data_in(a_d), .write_in(a_w), .dequeue_in(a_deq),
    .ovf_clr_in(a_clr), .status_out(a_status), .data_out(a_dout), .data_valid(a_dv),
    .len_out(a_len), .full_out(a_full), .empty_out(a_empty), .overflow_out(a_ovf));

  deser_fifo #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b0), .DROP_ON_FULL(1'b1)) u_b (
    .clock1M(clk), .reset(rst_n), .data_in(b_d), .write_in(b_w), .dequeue_in(b_deq),
    .ovf_clr_in(b_clr), .status_out(b_status), .data_out(b_dout), .data_valid(b_dv),
    .len_out(b_len), .full_out(b_full), .empty_out(b_empty), .overflow_out(b_ovf));

  bit act = 1'b0;  // 0 = instance a, 1 = instance b
  logic o_status, o_dv, o_full, o_empty, o_ovf;
  logic [7:0] o_dout;
  logic [3:0] o_len;
  assign o_status = act ? b_status : a_status;
  assign o_dv     = act ? b_dv     : a_dv;
  assign o_full   = act ? b_full   : a_full;
  assign o_empty  = act ? b_empty  : a_empty;
  assign o_ovf    = act ? b_ovf    : a_ovf;
  assign o_dout   = act ? b_dout   : a_dout;
  assign o_len    = act ? b_len    : a_len;

  int total = 0;
  int bad   = 0;

  // Reference model: word queue, collected bits, pending word awaiting a slot.
  logic [7:0] mq[$];
  bit         mbits[$];
  bit         mpend;
  logic [7:0] mpword;
  bit         movf;
  logic [7:0] mdout;
  bit         mdv;
  bit         mmsb, mdrop;

  task automatic model_clear();
    mq.delete(); mbits.delete();
    mpend = 0; mpword = '0; movf = 0; mdout = '0; mdv = 0;
  endtask

  task automatic drive(input bit d, input bit w, input bit deq, input bit clr);
    if (!act) begin
      a_d = d; a_w = w; a_deq = deq; a_clr = clr;
      b_d = 0; b_w = 0; b_deq = 0; b_clr = 0;
    end else begin
      b_d = d; b_w = w; b_deq = deq; b_clr = clr;
      a_d = 0; a_w = 0; a_deq = 0; a_clr = 0;
    end
  endtask

  // One clock cycle starting at a falling edge; checks against the model.
  task automatic cyc(input bit d, input bit w, input bit deq, input bit clr);
    bit pop, dropped;
    logic [7:0] popped, word;
    drive(d, w, deq, clr);
    #1;
    total++;
    if (o_status !== !mpend) begin
      bad++; $display("FAIL status: got %b want %b t=%0t", o_status, !mpend, $time);
    end
    @(posedge clk);
    pop = deq && (mq.size() > 0);
    dropped = 0;
    popped = '0;
    if (pop) popped = mq.pop_front();
    if (mpend) begin
      if (mq.size() < 8) begin
        mq.push_back(mpword); mpend = 0;
      end else if (mdrop) begin
        dropped = 1; mpend = 0;
      end
    end else if (w) begin
      mbits.push_back(d);
      if (mbits.size() == 8) begin
        word = '0;
        for (int i = 0; i < 8; i++) begin
          if (mmsb) word[7-i] = mbits[i];
          else      word[i]   = mbits[i];
        end
        mpword = word; mpend = 1; mbits.delete();
      end
    end
    if (dropped) movf = 1;
    else if (clr) movf = 0;
    mdv = pop;
    if (pop) mdout = popped;
    #1;
    total++;
    if (o_len !== 4'(mq.size())) begin
      bad++; $display("FAIL len: got %0d want %0d t=%0t", o_len, mq.size(), $time);
    end
    total++;
    if ({o_full, o_empty} !== {mq.size() == 8, mq.size() == 0}) begin
      bad++; $display("FAIL full/empty: got %b%b want %b%b t=%0t", o_full, o_empty,
                      mq.size() == 8, mq.size() == 0, $time);
    end
    total++;
    if (o_ovf !== movf) begin
      bad++; $display("FAIL overflow: got %b want %b t=%0t", o_ovf, movf, $time);
    end
    total++;
    if ({o_dv, o_dout} !== {mdv, mdout}) begin
      bad++; $display("FAIL data: got dv=%b %h want dv=%b %h t=%0t", o_dv, o_dout, mdv, mdout, $time);
    end
    @(negedge clk);
  endtask

  // Asserts reset asynchronously mid-cycle and checks outputs before any clock edge.
  task automatic apply_reset(input bit which);
    drive(0, 0, 0, 0);
    act = which;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_status, o_dout, o_dv, o_len, o_full, o_empty, o_ovf} !== {1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_values: got st=%b d=%h dv=%b len=%0d f=%b e=%b ovf=%b", o_status,
                      o_dout, o_dv, o_len, o_full, o_empty, o_ovf);
    end
    model_clear();
    mmsb  = !which;
    mdrop = which;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] word);
    for (int i = 0; i < 8; i++) cyc(mmsb ? word[7-i] : word[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill_fifo();
    for (int i = 0; i < 8; i++) begin
      send_word(8'(i));
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    apply_reset(1'b0);
  endtask

  task automatic test_single_word();
    apply_reset(1'b0);
    send_word(8'hA5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if (o_dout !== 8'hA5) begin bad++; $display("FAIL msb_word: got %h want a5", o_dout); end
    cyc(0, 0, 1, 0);  // pop on empty is ignored
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_lsb_first();
    bit s[8];
    apply_reset(1'b1);
    send_word(8'hA5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if (o_dout !== 8'hA5) begin bad++; $display("FAIL lsb_palindrome: got %h want a5", o_dout); end
    s = '{1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) cyc(s[i], 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if (o_dout !== 8'h01) begin bad++; $display("FAIL lsb_first_bit: got %h want 01", o_dout); end
  endtask

  task automatic test_stall_full();
    apply_reset(1'b0);
    fill_fifo();
    total++;
    if ({o_full, o_len} !== {1'b1, 4'd8}) begin
      bad++; $display("FAIL stall_full: got full=%b len=%0d want 1/8", o_full, o_len);
    end
    send_word(8'h08);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);  // lost while stalled
    cyc(0, 0, 1, 0);
    total++;
    if ({o_dout, o_len} !== {8'h00, 4'd8}) begin
      bad++; $display("FAIL stall_release: got %h len=%0d want 00 len=8", o_dout, o_len);
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    total++;
    if (o_dout !== 8'h08) begin bad++; $display("FAIL stall_last: got %h want 08", o_dout); end
  endtask

  task automatic test_drop();
    apply_reset(1'b1);
    fill_fifo();
    send_word(8'hFF);
    cyc(0, 0, 0, 0);
    total++;
    if ({o_ovf, o_len} !== {1'b1, 4'd8}) begin
      bad++; $display("FAIL drop: got ovf=%b len=%0d want 1/8", o_ovf, o_len);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
      total++;
      if (o_dout !== 8'(i)) begin bad++; $display("FAIL drop_order: got %h want %h", o_dout, 8'(i)); end
    end
    cyc(0, 0, 0, 1);
    total++;
    if ({o_ovf, o_empty} !== 2'b01) begin
      bad++; $display("FAIL ovf_clear: got ovf=%b empty=%b want 0/1", o_ovf, o_empty);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset(1'b0);
    fill_fifo();
    send_word(8'h5A);
    cyc(0, 0, 1, 0);  // PUSH cycle with simultaneous pop
    total++;
    if ({o_dout, o_len} !== {8'h00, 4'd8}) begin
      bad++; $display("FAIL push_pop_full: got %h len=%0d want 00 len=8", o_dout, o_len);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    total++;
    if (o_dout !== 8'h5A) begin bad++; $display("FAIL push_pop_last: got %h want 5a", o_dout); end
  endtask

  task automatic test_reset_partial();
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(8'h10 + 8'(i));
      cyc(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    apply_reset(1'b0);
    send_word(8'h3C);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if ({o_dout, o_empty} !== {8'h3C, 1'b1}) begin
      bad++; $display("FAIL reset_partial: got %h empty=%b want 3c/1", o_dout, o_empty);
    end
  endtask

  task automatic test_random(input bit which);
    apply_reset(which);
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
          (i < 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0),
          $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_lsb_first();
    test_stall_full();
    test_drop();
    test_full_push_pop();
    test_reset_partial();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deser_fifo.md
Name: deser_fifo

Overview:
- Parametrised serial-to-parallel receiver with integrated word FIFO, all on one clock.
- Shifts in WIDTH serial bits qualified by write_in, assembles a word and pushes it into a DEPTH-entry FIFO.
- The consumer pops words with dequeue_in.
- Replaces the fixed 8-bit deserializer plus 8-deep queue plus two-clock glue with a single-clock block.
- Adds configurable bit order, configurable overflow policy and status flags.

Parameters:
- WIDTH, 8: bits per assembled word; legal range 2..32.
- DEPTH, 8: FIFO entries; power of two, legal range 2..64.
- MSB_FIRST, 1: 1 = first received bit lands in data bit WIDTH-1; 0 = first bit lands in bit 0.
- DROP_ON_FULL, 0: 0 = stall the serial input while the FIFO is full; 1 = discard the word and flag overflow.

Ports:
- clock1M  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  1  serial data bit.
- write_in  input  1  data_in is valid this cycle.
- dequeue_in  input  1  pop request from consumer.
- ovf_clr_in  input  1  synchronous clear of overflow_out.
- status_out  output  1  1 = receiver accepts a bit this cycle.
- data_out  output  WIDTH  last popped word (registered).
- data_valid  output  1  one-cycle pulse; data_out was updated this cycle.
- len_out  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- full_out  output  1  len_out == DEPTH.
- empty_out  output  1  len_out == 0.
- overflow_out  output  1  sticky; a word was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - status_out=1, data_out=0, data_valid=0, len_out=0, empty_out=1, full_out=0, overflow_out=0.
  - Bit counter=0, shift register=0, FIFO pointers=0.
  - Reset during a partial word discards that word; FIFO contents are lost.
- Receiver FSM has two states, RECV and PUSH.
  - RECV: status_out=1. A bit is accepted when write_in=1.
    - Shift direction per MSB_FIRST.
    - Bit counter increments, wrapping WIDTH-1 -> 0.
    - On acceptance of bit WIDTH-1, the complete word moves to the hold register; next state is PUSH.
    - write_in=0 holds all state; there is no timeout.
  - PUSH: status_out=0; write_in is ignored and bits presented here are lost.
    - Push permitted if full_out=0, or if dequeue_in=1 and empty_out=0 in the same cycle.
    - If permitted: word written at the write pointer, pointer wraps modulo DEPTH, next state RECV.
    - If not permitted and DROP_ON_FULL=0: remain in PUSH.
    - If not permitted and DROP_ON_FULL=1: discard the word, set overflow_out=1, next state RECV.
  - Minimum spacing is WIDTH+1 cycles per word; status_out is low for exactly one cycle when space exists.
- Dequeue:
  - dequeue_in=1 and empty_out=0: data_out <= head word, data_valid=1 next cycle, read pointer advances.
  - dequeue_in=1 and empty_out=1: ignored; data_out holds, data_valid=0.
  - data_out holds its value between pops.
- Occupancy:
  - len_out +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - full_out and empty_out are derived from the registered len_out.
  - Simultaneous push and pop at len_out=DEPTH is legal: the popped word is the old head and len_out stays DEPTH.
- Overflow:
  - overflow_out is set only by a drop.
  - Cleared by ovf_clr_in=1 on the next edge; if a drop occurs in the same cycle, set wins.
  - overflow_out is always 0 when DROP_ON_FULL=0.
- Order: FIFO is strict first-in first-out; no reordering, no duplication.

Test Plan:
- Reset, then shift bits 1,0,1,0,0,1,0,1 (WIDTH=8, MSB_FIRST=1), then dequeue -> data_out=8'hA5, data_valid pulses once, len_out goes 1 then 0.
- Same bit stream with MSB_FIRST=0 -> data_out=8'hA5 bit-reversed, i.e. 8'hA5 (palindrome check); then repeat with stream 1,0,0,0,0,0,0,0 -> 8'h01.
- Push 8 words 8'h00..8'h07 without dequeue (DROP_ON_FULL=0) -> full_out=1, len_out=8, status_out stays 0 while a 9th word waits in PUSH; one dequeue returns 8'h00 and the 9th word enters the next cycle.
- DROP_ON_FULL=1, fill FIFO, send word 8'hFF -> overflow_out=1, len_out stays 8, dequeues return 8'h00..8'h07 and never 8'hFF; assert ovf_clr_in -> overflow_out=0 next cycle.
- Full FIFO, last bit of a new word accepted while dequeue_in=1 in the PUSH cycle -> len_out stays 8, data_out=oldest word, new word stored last.
- Assert reset=0 after 5 of 8 bits of a word with len_out=3 -> all outputs at reset values immediately; next complete 8-bit word dequeues intact.
